// File: rtl/display_sequencer_if.sv
// ---------------------------------------------------------------------------
// display_sequencer_if
//   Bundles the two source handshakes (req/data/ack for operand A and
//   result B) and the display-side outputs of display_sequencer.
//
//   Handshake: a source raises req_x with data_x and keeps data_x stable.
//   The sequencer answers with a 1-cycle ack_x pulse in the cycle after
//   the grant, which is when data_x has been captured. The source must
//   drop req_x after seeing ack_x; a req_x still high when the sequencer
//   next arbitrates counts as a new request.
//
//   master : request side (sources plus display observer)
//   slave  : the sequencer
//   state  : FSM state for observation (0 IDLE, 1 CONV, 2 HOLD)
// ---------------------------------------------------------------------------
interface display_sequencer_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic       src;
  logic       busy;
  logic       hold;
  logic       done;
  logic [1:0] state;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, dig0, dig1, dig2, src, busy, hold, done, state
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, dig0, dig1, dig2, src, busy, hold, done, state
  );
endinterface

// File: rtl/display_sequencer.sv
// ---------------------------------------------------------------------------
// display_sequencer
//   Arbitrates operand entry (A) and ALU result (B) for a 3-digit
//   seven-segment display, converts the granted 8-bit value to BCD with a
//   serial double-dabble (one iteration per clock, 8 iterations) and holds
//   a freshly shown result for HOLD_MS milliseconds before operand entry
//   may take the display back. B always wins arbitration.
//
//   Optional feature macro: LEADING_BLANK_EN
//     When defined, leading zero digits are written as 4'hF (blank).
//
//   Parameters
//     CLK_DIV : clk cycles per 1 ms hold tick
//     HOLD_MS : result hold time in ms (0..4095), 0 disables hold
//
//   Ports
//     clk  : clock
//     rst  : synchronous, active-high reset
//     bus  : display_sequencer_if.slave
//            req_a/data_a/ack_a, req_b/data_b/ack_b  source handshakes
//            dig0/dig1/dig2  ones/tens/hundreds digits
//            src   source of shown digits (0 A, 1 B)
//            busy  high in CONV, hold high in HOLD
//            done  1-cycle pulse, first cycle new digits are visible
//            state FSM state for observation
// ---------------------------------------------------------------------------
module display_sequencer #(
  parameter int CLK_DIV = 16000,
  parameter int HOLD_MS = 2000
) (
  input logic               clk,
  input logic               rst,
  display_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [11:0]   HOLD_LD   = 12'(HOLD_MS);

`ifdef LEADING_BLANK_EN
  localparam logic [11:0] DIG_RST = 12'hFF0;
`else
  localparam logic [11:0] DIG_RST = 12'h000;
`endif

  state_t        state_q,    state_d;
  logic [19:0]   shift_q,    shift_d;
  logic [2:0]    iter_q,     iter_d;
  logic          src_q,      src_d;
  logic          ack_a_q,    ack_a_d;
  logic          ack_b_q,    ack_b_d;
  logic          done_q,     done_d;
  logic [11:0]   dig_q,      dig_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [11:0]   hold_cnt_q, hold_cnt_d;

  logic          tick;
  logic [19:0]   step;

  // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  // Leading-zero blanking; the ones digit is always shown.
  function automatic logic [11:0] blank_lead(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
`ifdef LEADING_BLANK_EN
    if (bcd[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (bcd[7:4] == 4'd0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  assign tick = (presc_q == PRESC_MAX);
  assign step = dabble_step(shift_q);

  // Prescaler runs regardless of state so hold ticks stay on a fixed grid.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    iter_d     = iter_q;
    src_d      = src_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    done_d     = 1'b0;
    dig_d      = dig_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_b) begin
          ack_b_d = 1'b1;
          shift_d = {12'b0, bus.data_b};
          iter_d  = 3'd0;
          src_d   = 1'b1;
          state_d = CONV;
        end else if (bus.req_a) begin
          ack_a_d = 1'b1;
          shift_d = {12'b0, bus.data_a};
          iter_d  = 3'd0;
          src_d   = 1'b0;
          state_d = CONV;
        end
      end

      CONV: begin
        shift_d = step;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          // Last iteration: register the result of this step directly.
          dig_d  = blank_lead(step[19:8]);
          done_d = 1'b1;
          if (src_q && (HOLD_LD != 12'd0)) begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HOLD: begin
        // A new result abandons the hold; req_a stays pending meanwhile.
        if (bus.req_b) begin
          ack_b_d = 1'b1;
          shift_d = {12'b0, bus.data_b};
          iter_d  = 3'd0;
          src_d   = 1'b1;
          state_d = CONV;
        end else if (tick) begin
          if (hold_cnt_q <= 12'd1) begin
            hold_cnt_d = 12'd0;
            state_d    = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - 12'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      iter_q     <= '0;
      src_q      <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      done_q     <= 1'b0;
      dig_q      <= DIG_RST;
      presc_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      iter_q     <= iter_d;
      src_q      <= src_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      done_q     <= done_d;
      dig_q      <= dig_d;
      presc_q    <= presc_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;
  assign bus.dig0  = dig_q[3:0];
  assign bus.dig1  = dig_q[7:4];
  assign bus.dig2  = dig_q[11:8];
  assign bus.src   = src_q;
  assign bus.busy  = (state_q == CONV);
  assign bus.hold  = (state_q == HOLD);
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule
